// File: rtl/fetch_execute_control_if.sv
// rtl/fetch_execute_control_if.sv - memory bus between the sequencer and main memory
interface fetch_execute_control_if #(
   parameter int DATA_W = 16
);
   logic [15:0]       mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_addr,
      output mem_wdata,
      output mem_we,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_wdata,
      input  mem_we,
      output mem_rdata
   );
endinterface

// File: rtl/fetch_execute_control.sv
// rtl/fetch_execute_control.sv - fetch/decode/execute sequencer for the accumulator machine
module fetch_execute_control #(
   parameter int                ADDR_W   = 12,
   parameter int                DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    run,
   fetch_execute_control_if.master mem,
   output logic [ADDR_W-1:0]       pc,
   output logic [DATA_W-1:0]       ac,
   output logic [DATA_W-1:0]       ir,
   output logic                    halted,
   output logic                    retire
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_IR_LOAD,
      S_DECODE,
      S_READ,
      S_EXEC,
      S_WRITE,
      S_HALTED
   } state_t;

   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUBT  = 4'h4;
   localparam logic [3:0] OP_HALT  = 4'h7;
   localparam logic [3:0] OP_SKIP  = 4'h8;
   localparam logic [3:0] OP_JUMP  = 4'h9;
   localparam logic [3:0] OP_CLEAR = 4'hA;

   state_t             state;
   logic [ADDR_W-1:0]  mar;
   logic [DATA_W-1:0]  mbr;
   logic [DATA_W-1:0]  mbr_next;
   logic [DATA_W-1:0]  alu_result;
   logic [ADDR_W-1:0]  addr_sel;
   logic               skip_taken;
   logic [3:0]         opcode;
   logic [ADDR_W-1:0]  operand;
   logic [3:0]         fetched_op;

   assign opcode     = ir[DATA_W-1 -: 4];
   assign operand    = ir[ADDR_W-1:0];
   assign fetched_op = mem.mem_rdata[DATA_W-1 -: 4];

   // Memory is addressed by MAR only while an operand access is in flight; otherwise it follows pc.
   assign addr_sel      = (state == S_READ || state == S_WRITE) ? mar : pc;
   assign mem.mem_addr  = 16'(addr_sel);
   assign mem.mem_wdata = ac;
   assign mem.mem_we    = (state == S_WRITE);

   // MBR captures the read word in EXEC; the ALU takes the same value so ac updates in that cycle.
   always_comb begin
      mbr_next = mbr;
      if (state == S_EXEC) begin
         mbr_next = mem.mem_rdata;
      end
   end

   // Accumulator update for the memory-operand instructions; arithmetic wraps silently.
   always_comb begin
      alu_result = ac;
      case (opcode)
         OP_LOAD: alu_result = mbr_next;
         OP_ADD:  alu_result = ac + mbr_next;
         OP_SUBT: alu_result = ac - mbr_next;
         default: alu_result = ac;
      endcase
   end

   // SKIPCOND condition select on the top two operand bits, treating ac as signed.
   always_comb begin
      skip_taken = 1'b0;
      case (operand[ADDR_W-1 -: 2])
         2'b00:   skip_taken = ac[DATA_W-1];
         2'b01:   skip_taken = (ac == '0);
         2'b10:   skip_taken = !ac[DATA_W-1] && (ac != '0);
         default: skip_taken = 1'b0;
      endcase
   end

   // Sequencer: state, architectural registers and the registered retire/halted outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_FETCH;
         pc     <= RESET_PC;
         ac     <= '0;
         ir     <= '0;
         mar    <= '0;
         mbr    <= '0;
         halted <= 1'b0;
         retire <= 1'b0;
      end else begin
         retire <= 1'b0;
         mbr    <= mbr_next;
         case (state)
            S_FETCH: begin
               if (run) begin
                  state <= S_IR_LOAD;
               end
            end
            S_IR_LOAD: begin
               ir    <= mem.mem_rdata;
               pc    <= pc + ADDR_W'(1);
               // Short instructions finish in DECODE, so announce retire one cycle ahead.
               retire <= !(fetched_op inside {OP_LOAD, OP_ADD, OP_SUBT, OP_STORE});
               state <= S_DECODE;
            end
            S_DECODE: begin
               mar <= operand;
               case (opcode)
                  OP_LOAD, OP_ADD, OP_SUBT: begin
                     state <= S_READ;
                  end
                  OP_STORE: begin
                     retire <= 1'b1;
                     state  <= S_WRITE;
                  end
                  OP_JUMP: begin
                     pc    <= operand;
                     state <= S_FETCH;
                  end
                  OP_CLEAR: begin
                     ac    <= '0;
                     state <= S_FETCH;
                  end
                  OP_SKIP: begin
                     if (skip_taken) begin
                        pc <= pc + ADDR_W'(1);
                     end
                     state <= S_FETCH;
                  end
                  OP_HALT: begin
                     halted <= 1'b1;
                     state  <= S_HALTED;
                  end
                  default: begin
                     state <= S_FETCH;
                  end
               endcase
            end
            S_READ: begin
               retire <= 1'b1;
               state  <= S_EXEC;
            end
            S_EXEC: begin
               ac    <= alu_result;
               state <= S_FETCH;
            end
            S_WRITE: begin
               state <= S_FETCH;
            end
            S_HALTED: begin
               state <= S_HALTED;
            end
            default: begin
               state <= S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_execute_control.sv
// tb/tb_fetch_execute_control.sv - self-checking bench for fetch_execute_control
module tb_fetch_execute_control;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        run   = 1'b1;
   logic [11:0] pc;
   logic [15:0] ac;
   logic [15:0] ir;
   logic        halted;
   logic        retire;

   fetch_execute_control_if #(.DATA_W(16)) bus ();

   fetch_execute_control #(
      .ADDR_W   (12),
      .DATA_W   (16),
      .RESET_PC (12'h000)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .run    (run),
      .mem    (bus),
      .pc     (pc),
      .ac     (ac),
      .ir     (ir),
      .halted (halted),
      .retire (retire)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [0:4095];
   logic [15:0] img [0:4095];
   logic        load = 1'b0;

   // Main memory: synchronous write, registered read; reloaded from img while load is high.
   always @(posedge clk) begin
      bus.mem_rdata <= mem[bus.mem_addr[11:0]];
      if (load) begin
         for (int i = 0; i < 4096; i++) mem[i] <= img[i];
      end else if (bus.mem_we) begin
         mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction-level model of the machine
   logic [15:0] m_mem [0:4095];
   logic [11:0] m_pc;
   logic [15:0] m_ac;
   logic        m_halted;
   int          cyc, start, n_retire;
   logic [15:0] c_w;
   logic [3:0]  c_op;
   logic [11:0] c_x;
   int          c_off, c_lat;
   logic        c_skip;

   function automatic int lat_of(input logic [3:0] op);
      if (op == 4'h1 || op == 4'h3 || op == 4'h4) return 5;
      if (op == 4'h2) return 4;
      return 3;
   endfunction

   // Compare process: every cycle, check the DUT against the instruction-level model.
   always @(negedge clk) begin
      if (reset) begin
         m_pc = 12'h000; m_ac = 16'h0; m_halted = 1'b0;
         cyc = 0; start = 0; n_retire = 0;
         if (load) for (int i = 0; i < 4096; i++) m_mem[i] = img[i];
      end else begin
         if (retire) n_retire++;
         check("addr_upper", bus.mem_addr[15:12], 4'h0);
         if (m_halted) begin
            check("halt_flag", halted, 1'b1);
            check("halt_we", bus.mem_we, 1'b0);
            check("halt_retire", retire, 1'b0);
            check("halt_addr", bus.mem_addr, {4'h0, m_pc});
            check("halt_pc", pc, m_pc);
            check("halt_ac", ac, m_ac);
         end else begin
            c_w   = m_mem[m_pc];
            c_op  = c_w[15:12];
            c_x   = c_w[11:0];
            c_off = cyc - start;
            c_lat = lat_of(c_op);
            check("mem_we", bus.mem_we, (c_op == 4'h2) && (c_off == 3));
            check("retire", retire, c_off == c_lat - 1);
            if (c_off == 0) begin
               check("fetch_addr", bus.mem_addr, {4'h0, m_pc});
               check("pc", pc, m_pc);
               check("ac", ac, m_ac);
               check("halted", halted, 1'b0);
               if (!run) start++;
            end
            if (c_off == 3 && c_op inside {4'h1, 4'h2, 4'h3, 4'h4}) begin
               check("operand_addr", bus.mem_addr, {4'h0, c_x});
               if (c_op == 4'h2) check("store_data", bus.mem_wdata, m_ac);
            end
            if (c_off == c_lat - 1) begin
               check("ir", ir, c_w);
               m_pc = m_pc + 12'h001;
               case (c_op)
                  4'h1: m_ac = m_mem[c_x];
                  4'h2: m_mem[c_x] = m_ac;
                  4'h3: m_ac = m_ac + m_mem[c_x];
                  4'h4: m_ac = m_ac - m_mem[c_x];
                  4'h7: m_halted = 1'b1;
                  4'h8: begin
                     case (c_x[11:10])
                        2'b00:   c_skip = $signed(m_ac) < 0;
                        2'b01:   c_skip = m_ac == 16'h0;
                        2'b10:   c_skip = $signed(m_ac) > 0;
                        default: c_skip = 1'b0;
                     endcase
                     if (c_skip) m_pc = m_pc + 12'h001;
                  end
                  4'h9: m_pc = c_x;
                  4'hA: m_ac = 16'h0;
                  default: ;
               endcase
               start = cyc + 1;
            end
         end
         cyc++;
      end
   end

   int cur = 0;

   task automatic begin_load();
      reset = 1'b1;
      for (int i = 0; i < 4096; i++) img[i] = 16'h0000;
   endtask

   task automatic release_reset();
      load = 1'b1;
      repeat (2) @(posedge clk);
      #1 load = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      cur = 0;
   endtask

   task automatic goto_cycle(input int m);
      repeat (m - cur) @(posedge clk);
      @(negedge clk);
      cur = m;
   endtask

   initial begin
      // Load/add/store program
      begin_load();
      img[12'h000] = 16'h1010; img[12'h001] = 16'h3011;
      img[12'h002] = 16'h2012; img[12'h003] = 16'h7000;
      img[12'h010] = 16'h0005; img[12'h011] = 16'h0007;
      run = 1'b1;
      #1 check("reset_we", bus.mem_we, 1'b0);
      check("reset_pc", pc, 12'h000);
      check("reset_ac", ac, 16'h0000);
      check("reset_ir", ir, 16'h0000);
      check("reset_halted", halted, 1'b0);
      check("reset_retire", retire, 1'b0);
      release_reset();
      goto_cycle(16);
      check("t1_halted_c16", halted, 1'b0);
      goto_cycle(17);
      check("t1_halted_c17", halted, 1'b1);
      check("t1_ac", ac, 16'h000C);
      check("t1_pc", pc, 12'h004);
      check("t1_mem12", mem[12'h012], 16'h000C);
      check("t1_retires", n_retire, 4);

      // Subtract underflow and skip-on-negative
      begin_load();
      img[12'h000] = 16'h1020; img[12'h001] = 16'h4021;
      img[12'h002] = 16'h8000; img[12'h003] = 16'h7000;
      img[12'h004] = 16'h7000;
      img[12'h020] = 16'h0003; img[12'h021] = 16'h0005;
      release_reset();
      goto_cycle(20);
      check("t2_ac", ac, 16'hFFFE);
      check("t2_pc", pc, 12'h005);
      check("t2_halted", halted, 1'b1);

      // Skip on zero vs positive vs never, with ac=0, then a NOP
      begin_load();
      img[12'h000] = 16'h8400; img[12'h001] = 16'h7000;
      img[12'h002] = 16'h8800; img[12'h003] = 16'h8C00;
      img[12'h004] = 16'hB123; img[12'h005] = 16'h7000;
      release_reset();
      goto_cycle(20);
      check("t3_pc", pc, 12'h006);
      check("t3_ac", ac, 16'h0000);
      check("t3_halted", halted, 1'b1);

      // PC wrap via jump to 0xFFF holding CLEAR
      begin_load();
      img[12'h000] = 16'h1030; img[12'h001] = 16'h9FFF;
      img[12'hFFF] = 16'hA000; img[12'h030] = 16'h1234;
      release_reset();
      goto_cycle(8);
      check("t4_addr_fff", bus.mem_addr, 16'h0FFF);
      check("t4_ac_loaded", ac, 16'h1234);
      goto_cycle(11);
      check("t4_addr_wrap", bus.mem_addr, 16'h0000);
      check("t4_ac_clear", ac, 16'h0000);
      check("t4_pc_wrap", pc, 12'h000);
      goto_cycle(20);

      // Hold with run low, then halt stickiness
      begin_load();
      img[12'h000] = 16'h7000;
      run = 1'b0;
      release_reset();
      goto_cycle(20);
      check("t5_hold_pc", pc, 12'h000);
      check("t5_hold_we", bus.mem_we, 1'b0);
      check("t5_hold_addr", bus.mem_addr, 16'h0000);
      @(posedge clk);
      #1 run = 1'b1;
      cur = 21;
      goto_cycle(30);
      check("t5_halted", halted, 1'b1);
      check("t5_pc", pc, 12'h001);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 run = ~run;
         @(negedge clk);
         check("t5_sticky", halted, 1'b1);
         check("t5_no_we", bus.mem_we, 1'b0);
         check("t5_no_fetch", bus.mem_addr, 16'h0001);
      end

      // Reset asserted during the WRITE cycle of a STORE
      begin_load();
      img[12'h000] = 16'h1040; img[12'h001] = 16'h2041;
      img[12'h040] = 16'h5555; img[12'h041] = 16'hAAAA;
      run = 1'b1;
      release_reset();
      goto_cycle(8);
      check("t6_we_before", bus.mem_we, 1'b1);
      check("t6_addr_before", bus.mem_addr, 16'h0041);
      check("t6_wdata_before", bus.mem_wdata, 16'h5555);
      #1 reset = 1'b1;
      #1 check("t6_we_dropped", bus.mem_we, 1'b0);
      check("t6_pc", pc, 12'h000);
      check("t6_ac", ac, 16'h0000);
      @(posedge clk);
      @(negedge clk);
      check("t6_mem_intact", mem[12'h041], 16'hAAAA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
